// File: rtl/dump_state_pkg.sv
// dump_state_pkg: shared types and constants for the channel state dump
// sequencer. Holds the FSM encoding, the state-image offset map and the
// word-index-to-offset helper used by dump_word_mux.
// Optional feature macro (used by dump_state_seq): DUMP_CHECKSUM_EN.
package dump_state_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FREEZE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } dump_state_t;

  // Fixed state words come first, then the accumulator block.
  localparam int NUM_FIXED_WORDS = 9;
  localparam int STATE_WORDS     = 10;  // words per channel on ch_state_flat (offsets 6..15)
  localparam int FIRST_STATE_OFS = 6;
  localparam int ACC_BASE_OFS    = 16;

  // Wide enough for 9 fixed + 16 accumulator + 1 checksum word.
  localparam int IDX_W = 5;
  // Wide enough for the largest offset (16 + 16 = 32).
  localparam int OFS_W = 6;

  // Offset 14 is deliberately absent: it is never written to state memory.
  localparam logic [OFS_W-1:0] FIXED_OFS [NUM_FIXED_WORDS] = '{
    6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd15
  };

  // Word index -> state-image offset. Indices past the fixed block map
  // linearly from ACC_BASE_OFS, which also covers the checksum slot.
  function automatic logic [OFS_W-1:0] word_ofs(input logic [IDX_W-1:0] idx);
    logic [OFS_W-1:0] ofs;
    ofs = OFS_W'(ACC_BASE_OFS) + OFS_W'(idx) - OFS_W'(NUM_FIXED_WORDS);
    for (int i = 0; i < NUM_FIXED_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        ofs = FIXED_OFS[i];
      end
    end
    return ofs;
  endfunction

endpackage

// File: rtl/dump_word_mux.sv
// dump_word_mux: combinational selector that returns the 32-bit state
// word and its image offset for a given channel and word index. Keeps the
// wide flattened-bus slicing away from the sequencer FSM.
import dump_state_pkg::*;

module dump_word_mux #(
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = 2,
  parameter int NUM_COR  = 8
) (
  input  logic [CH_IDX_W-1:0]            ch,
  input  logic [IDX_W-1:0]               idx,
  input  logic [NUM_CH*10*32-1:0]        ch_state_flat,
  input  logic [NUM_CH*NUM_COR*32-1:0]   ch_acc_flat,
  output logic [31:0]                    word,
  output logic [OFS_W-1:0]               ofs
);

  logic [31:0] state_w [NUM_CH][STATE_WORDS];
  logic [31:0] acc_w   [NUM_CH][NUM_COR];

  // Unflatten the channel buses into per-channel word arrays.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    for (genvar gj = 0; gj < STATE_WORDS; gj++) begin : g_state
      assign state_w[gi][gj] = ch_state_flat[(gi*STATE_WORDS+gj)*32 +: 32];
    end
    for (genvar gk = 0; gk < NUM_COR; gk++) begin : g_acc
      assign acc_w[gi][gk] = ch_acc_flat[(gi*NUM_COR+gk)*32 +: 32];
    end
  end

  // Select the word: fixed words by offset, accumulators by index.
  // Indices beyond the accumulator block return zero.
  always_comb begin
    word = '0;
    ofs  = word_ofs(idx);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CH_IDX_W'(c)) begin
        for (int j = 0; j < STATE_WORDS; j++) begin
          if ((idx < IDX_W'(NUM_FIXED_WORDS)) && (ofs == OFS_W'(j + FIRST_STATE_OFS))) begin
            word = state_w[c][j];
          end
        end
        for (int k = 0; k < NUM_COR; k++) begin
          if (idx == IDX_W'(NUM_FIXED_WORDS + k)) begin
            word = acc_w[c][k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dump_state_seq.sv
// dump_state_seq: freezes one correlator channel and streams its state
// image (offsets 6..13, 15, then the accumulators from 16) into state
// memory over a backpressured write port.
// Optional feature macro: DUMP_CHECKSUM_EN -- appends an XOR checksum word
// at offset 16+NUM_COR after the accumulator block.
import dump_state_pkg::*;

module dump_state_seq #(
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = 2,
  parameter int NUM_COR  = 8,
  parameter int ADDR_W   = 10
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          dump_req,
  input  logic [CH_IDX_W-1:0]           dump_ch,
  input  logic [ADDR_W-1:0]             dump_base,
  output logic                          dump_busy,
  output logic                          dump_done,
  output logic                          dump_err,
  output logic [NUM_CH-1:0]             freeze_ch,
  input  logic [NUM_CH*10*32-1:0]       ch_state_flat,
  input  logic [NUM_CH*NUM_COR*32-1:0]  ch_acc_flat,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ready
);

`ifdef DUMP_CHECKSUM_EN
  localparam int NUM_WORDS = NUM_FIXED_WORDS + NUM_COR + 1;
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_FIXED_WORDS + NUM_COR);
`else
  localparam int NUM_WORDS = NUM_FIXED_WORDS + NUM_COR;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  dump_state_t         state_reg, state_next;
  logic [CH_IDX_W-1:0] ch_reg, ch_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic [NUM_CH-1:0]   freeze_reg, freeze_next;

  logic [IDX_W-1:0]    load_idx;
  logic [31:0]         mux_word;
  logic [OFS_W-1:0]    mux_ofs;
  logic [31:0]         load_word;

  dump_word_mux #(
    .NUM_CH   (NUM_CH),
    .CH_IDX_W (CH_IDX_W),
    .NUM_COR  (NUM_COR)
  ) u_word_mux (
    .ch            (ch_reg),
    .idx           (load_idx),
    .ch_state_flat (ch_state_flat),
    .ch_acc_flat   (ch_acc_flat),
    .word          (mux_word),
    .ofs           (mux_ofs)
  );

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] csum_reg, csum_next;

  // Checksum slot carries the running XOR; every other slot the channel word.
  always_comb begin
    load_word = (load_idx == CSUM_IDX) ? csum_reg : mux_word;
  end

  // Running XOR of words loaded so far; cleared on accept.
  always_comb begin
    csum_next = csum_reg;
    if ((state_reg == IDLE) && dump_req) begin
      csum_next = '0;
    end else if ((state_reg == FREEZE) ||
                 ((state_reg == WRITE) && we_reg && mem_ready && (idx_reg != LAST_IDX))) begin
      csum_next = csum_reg ^ load_word;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      csum_reg <= '0;
    end else begin
      csum_reg <= csum_next;
    end
  end
`else
  // Without the checksum every slot is a channel word.
  always_comb begin
    load_word = mux_word;
  end
`endif

  // Next-state and registered-output logic for the dump sequencer.
  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    base_next   = base_reg;
    idx_next    = idx_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    busy_next   = busy_reg;
    freeze_next = freeze_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    load_idx    = idx_reg + IDX_W'(1);

    // Any request outside IDLE is refused; the running dump carries on.
    if (dump_req && (state_reg != IDLE)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (dump_req) begin
          if (32'(dump_ch) < NUM_CH) begin
            ch_next     = dump_ch;
            base_next   = dump_base;
            idx_next    = '0;
            busy_next   = 1'b1;
            freeze_next = NUM_CH'(1) << dump_ch;
            state_next  = FREEZE;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      FREEZE: begin
        // Channel has had a cycle to hold; capture word 0.
        load_idx   = '0;
        idx_next   = '0;
        we_next    = 1'b1;
        addr_next  = base_reg + ADDR_W'(mux_ofs);
        wdata_next = load_word;
        state_next = WRITE;
      end

      WRITE: begin
        if (we_reg && mem_ready) begin
          if (idx_reg == LAST_IDX) begin
            we_next     = 1'b0;
            busy_next   = 1'b0;
            freeze_next = '0;
            done_next   = 1'b1;
            state_next  = DONE;
          end else begin
            idx_next   = load_idx;
            addr_next  = base_reg + ADDR_W'(mux_ofs);
            wdata_next = load_word;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns every output to zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg  <= IDLE;
      ch_reg     <= '0;
      base_reg   <= '0;
      idx_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      freeze_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ch_reg     <= ch_next;
      base_reg   <= base_next;
      idx_reg    <= idx_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      freeze_reg <= freeze_next;
    end
  end

  assign dump_busy = busy_reg;
  assign dump_done = done_reg;
  assign dump_err  = err_reg;
  assign freeze_ch = freeze_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_dump_state_seq.sv
// tb_dump_state_seq: directed and randomized checks of dump_state_seq
// against a word-list reference model (offset list, address wrap, XOR).
// Honours DUMP_CHECKSUM_EN the same way as the design.
module tb_dump_state_seq;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 3;
  localparam int NUM_COR  = 8;
  localparam int ADDR_W   = 10;
`ifdef DUMP_CHECKSUM_EN
  localparam int W = 9 + NUM_COR + 1;
`else
  localparam int W = 9 + NUM_COR;
`endif

  logic                         clk = 1'b0;
  logic                         rst_b = 1'b0;
  logic                         dump_req = 1'b0;
  logic [CH_IDX_W-1:0]          dump_ch = '0;
  logic [ADDR_W-1:0]            dump_base = '0;
  logic                         dump_busy, dump_done, dump_err;
  logic [NUM_CH-1:0]            freeze_ch;
  logic [NUM_CH*10*32-1:0]      ch_state_flat = '0;
  logic [NUM_CH*NUM_COR*32-1:0] ch_acc_flat = '0;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [31:0]                  mem_wdata;
  logic                         mem_ready = 1'b1;

  dump_state_seq #(
    .NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W), .NUM_COR(NUM_COR), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .dump_req(dump_req), .dump_ch(dump_ch),
    .dump_base(dump_base), .dump_busy(dump_busy), .dump_done(dump_done),
    .dump_err(dump_err), .freeze_ch(freeze_ch), .ch_state_flat(ch_state_flat),
    .ch_acc_flat(ch_acc_flat), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] st_w  [NUM_CH][10];
  logic [31:0] acc_w [NUM_CH][NUM_COR];
  int          exp_addr [$];
  logic [31:0] exp_data [$];
  int          fixed_ofs [9] = '{6, 7, 8, 9, 10, 11, 12, 13, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < 10; j++) ch_state_flat[(c*10+j)*32 +: 32] = st_w[c][j];
      for (int k = 0; k < NUM_COR; k++) ch_acc_flat[(c*NUM_COR+k)*32 +: 32] = acc_w[c][k];
    end
  endtask

  task automatic randomize_words();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < 10; j++) st_w[c][j] = $urandom();
      for (int k = 0; k < NUM_COR; k++) acc_w[c][k] = $urandom();
    end
    pack_inputs();
  endtask

  // Reference image: offset list, then accumulators, then optional XOR word.
  task automatic build_expected(input int ch, input int base);
    logic [31:0] x;
    int ofs;
    exp_addr.delete();
    exp_data.delete();
    x = '0;
    for (int k = 0; k < W; k++) begin
      if (k < 9) begin
        ofs = fixed_ofs[k];
        exp_data.push_back(st_w[ch][ofs-6]);
      end else if (k < 9 + NUM_COR) begin
        ofs = 16 + (k - 9);
        exp_data.push_back(acc_w[ch][k-9]);
      end else begin
        ofs = 16 + NUM_COR;
        exp_data.push_back(x);
      end
      x = x ^ exp_data[k];
      exp_addr.push_back((base + ofs) % (1 << ADDR_W));
    end
  endtask

  // One full dump; stall_mode=1 drops mem_ready every other cycle;
  // inj_cycle is the cycle in which a second request is fired (<0: none).
  task automatic run_dump(input int ch, input int base, input int stall_mode, input int inj_cycle);
    int n, last_acc;
    bit done_seen, prev_pend;
    logic [31:0] prev_a, prev_d;
    build_expected(ch, base);
    @(negedge clk);
    dump_req = 1'b1; dump_ch = CH_IDX_W'(ch); dump_base = ADDR_W'(base); mem_ready = 1'b1;
    n = 0; last_acc = -1; done_seen = 1'b0; prev_pend = 1'b0; prev_a = '0; prev_d = '0;
    for (int cyc = 1; cyc <= 200 && !done_seen; cyc++) begin
      @(negedge clk);
      dump_req = (cyc == inj_cycle);
      if (cyc == inj_cycle) begin
        dump_ch = CH_IDX_W'((ch + 1) % NUM_CH);
        dump_base = ADDR_W'($urandom());
      end
      if (cyc == 1) begin
        chk("freeze_ch_c1", 32'(freeze_ch), 32'(1 << ch));
        chk("busy_c1", dump_busy, 1'b1);
        chk("we_c1", mem_we, 1'b0);
      end
      chk("err", dump_err, (cyc == inj_cycle + 1));
      if (prev_pend) begin
        chk("hold_we", mem_we, 1'b1);
        chk("hold_addr", 32'(mem_addr), 32'(prev_a));
        chk("hold_data", mem_wdata, prev_d);
      end
      if (dump_done) begin
        done_seen = 1'b1;
        chk("done_count", 32'(n), 32'(W));
        if (stall_mode == 0) chk("done_cycle", 32'(cyc), 32'(W + 2));
        else chk("done_cycle", 32'(cyc), 32'(last_acc + 1));
      end else begin
        chk("busy", dump_busy, 1'b1);
        chk("freeze_ch", 32'(freeze_ch), 32'(1 << ch));
        mem_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        if (mem_we) begin
          if (n >= W) begin
            chk("extra_write", mem_we, 1'b0);
          end else if (mem_ready) begin
            chk("addr", 32'(mem_addr), 32'(exp_addr[n]));
            chk("data", mem_wdata, exp_data[n]);
            if (stall_mode == 0) chk("write_cycle", 32'(cyc), 32'(n + 2));
            $display("write %0d ch=%0d addr=%03h data=%08h cycle=%0d", n, ch, mem_addr, mem_wdata, cyc);
            n++;
            last_acc = cyc;
          end
        end
        prev_pend = mem_we && !mem_ready;
        prev_a = 32'(mem_addr);
        prev_d = mem_wdata;
      end
    end
    dump_req = 1'b0;
    mem_ready = 1'b1;
    if (!done_seen) chk("timeout_done", 1'b0, 1'b1);
    @(negedge clk);
    chk("post_busy", dump_busy, 1'b0);
    chk("post_freeze", 32'(freeze_ch), 32'(0));
    chk("post_done", dump_done, 1'b0);
    chk("post_we", mem_we, 1'b0);
    $display("dump ch=%0d base=%03h stall=%0d writes=%0d", ch, base, stall_mode, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, dump_busy, 1'b0);
    chk({tag, "_done"}, dump_done, 1'b0);
    chk({tag, "_err"}, dump_err, 1'b0);
    chk({tag, "_freeze"}, 32'(freeze_ch), 32'(0));
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_wdata"}, mem_wdata, 32'(0));
  endtask

  initial begin
    int cnt, rbase;
    bit hit;

    // Reset state
    randomize_words();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_b = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Basic dump, mem_ready tied high
    run_dump(2, 'h100, 0, -5);

    // Out-of-range channel is rejected
    @(negedge clk);
    dump_req = 1'b1; dump_ch = 3'd5; dump_base = 'h100;
    @(negedge clk);
    dump_req = 1'b0;
    chk("bad_ch_err", dump_err, 1'b1);
    chk("bad_ch_busy", dump_busy, 1'b0);
    chk("bad_ch_we", mem_we, 1'b0);
    @(negedge clk);
    chk("bad_ch_err_clear", dump_err, 1'b0);
    chk("bad_ch_idle_we", mem_we, 1'b0);
    $display("reject ch=5 err pulse checked");

    // Address wrap plus a refused request in mid-dump
    randomize_words();
    run_dump(1, 'h3FA, 0, 6);

    // Backpressure every other cycle
    randomize_words();
    run_dump(3, int'($urandom_range(0, 1023)), 1, -5);

    // Reset asserted at the 5th write
    randomize_words();
    rbase = int'($urandom_range(0, 1023));
    @(negedge clk);
    dump_req = 1'b1; dump_ch = 3'd0; dump_base = ADDR_W'(rbase);
    cnt = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (mem_we) begin
        if (cnt == 4) begin
          hit = 1'b1;
          rst_b = 1'b0;
          #1;
          chk_all_zero("midreset");
          $display("reset asserted at write %0d", cnt + 1);
        end
        cnt++;
      end
    end
    if (!hit) chk("timeout_midreset", 1'b0, 1'b1);
    @(negedge clk);
    chk_all_zero("held_reset");
    rst_b = 1'b1;
    run_dump(0, rbase, 0, -5);

    // Randomized dumps
    for (int t = 0; t < 4; t++) begin
      randomize_words();
      run_dump(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1)), -5);
    end

    // Patterned image (exercises the checksum word when enabled)
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < 10; j++) st_w[c][j] = 32'hA5A5A5A5;
      for (int k = 0; k < NUM_COR; k++) acc_w[c][k] = 32'hA5A5A5A5;
      acc_w[c][0] = 32'h0000FFFF;
    end
    pack_inputs();
    run_dump(2, 'h100, 0, -5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
